// File: rtl/text_writer.sv
// text_writer: byte stream to text-cell writes with cursor, wrap and screen clear (option TEXT_WRITER_CLEAR_ON_RESET_EN fills the screen on reset)
module text_writer #(
  parameter int COLS   = 100,
  parameter int ROWS   = 37,
  parameter int COL_W  = 7,
  parameter int ROW_W  = 6,
  parameter int ATTR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic [ATTR_W-1:0] in_attr,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              write,
  output logic [COL_W-1:0]  xtextwrite,
  output logic [ROW_W-1:0]  ytextwrite,
  output logic [ATTR_W+7:0] value,
  output logic [COL_W-1:0]  cursor_x,
  output logic [ROW_W-1:0]  cursor_y,
  output logic              busy
);
  localparam logic [COL_W-1:0] X_MAX = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] Y_MAX = ROW_W'(ROWS - 1);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t              state, state_n;
  logic [COL_W-1:0]    cx_n, fx, fx_n, xw_n;
  logic [ROW_W-1:0]    cy_n, fy, fy_n, yw_n;
  logic [ATTR_W-1:0]   fill_attr, attr_n;
  logic [ATTR_W+7:0]   value_n;
  logic                last, last_n, write_n, accept;
  assign in_ready = state == IDLE;
  assign accept   = in_valid & in_ready;
  always_comb begin
    state_n = state;
    cx_n    = cursor_x;
    cy_n    = cursor_y;
    fx_n    = fx;
    fy_n    = fy;
    last_n  = last;
    attr_n  = fill_attr;
    write_n = 1'b0;
    xw_n    = xtextwrite;
    yw_n    = ytextwrite;
    value_n = value;
    if (state == CLEAR) begin
      if (last) begin
        state_n = IDLE;
        cx_n    = '0;
        cy_n    = '0;
      end else begin
        write_n = 1'b1;
        xw_n    = fx;
        yw_n    = fy;
        value_n = {fill_attr, 8'h20};
        fx_n    = fx == X_MAX ? '0 : fx + 1'b1;
        fy_n    = fx != X_MAX ? fy : fy == Y_MAX ? '0 : fy + 1'b1;
        last_n  = fx == X_MAX && fy == Y_MAX;
      end
    end else if (accept) begin
      if (in_data >= 8'h20) begin
        write_n = 1'b1;
        xw_n    = cursor_x;
        yw_n    = cursor_y;
        value_n = {in_attr, in_data};
        cx_n    = cursor_x == X_MAX ? '0 : cursor_x + 1'b1;
        cy_n    = cursor_x != X_MAX ? cursor_y : cursor_y == Y_MAX ? '0 : cursor_y + 1'b1;
      end else if (in_data == 8'h0D) begin
        cx_n = '0;
      end else if (in_data == 8'h0A) begin
        cy_n = cursor_y == Y_MAX ? '0 : cursor_y + 1'b1;
      end else if (in_data == 8'h08) begin
        cx_n = cursor_x == '0 ? '0 : cursor_x - 1'b1;
      end else if (in_data == 8'h0C) begin
        state_n = CLEAR;
        attr_n  = in_attr;
        fx_n    = '0;
        fy_n    = '0;
        last_n  = 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef TEXT_WRITER_CLEAR_ON_RESET_EN
      state     <= CLEAR;
      fill_attr <= ATTR_W'(8'h07);
      busy      <= 1'b1;
`else
      state     <= IDLE;
      fill_attr <= '0;
      busy      <= 1'b0;
`endif
      cursor_x   <= '0;
      cursor_y   <= '0;
      fx         <= '0;
      fy         <= '0;
      last       <= 1'b0;
      write      <= 1'b0;
      xtextwrite <= '0;
      ytextwrite <= '0;
      value      <= '0;
    end else begin
      state      <= state_n;
      fill_attr  <= attr_n;
      busy       <= state_n == CLEAR;
      cursor_x   <= cx_n;
      cursor_y   <= cy_n;
      fx         <= fx_n;
      fy         <= fy_n;
      last       <= last_n;
      write      <= write_n;
      xtextwrite <= xw_n;
      ytextwrite <= yw_n;
      value      <= value_n;
    end
  end
endmodule
